// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, prefetch entry layout
// and the default boot address.
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

   typedef enum logic {
      FETCH,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory read bus, redirect input and
// the valid/ready hand-off to the control path.
interface instr_fetch_unit_if;

   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_waitrequest;
   logic [31:0] imem_readdata;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_word;
   logic [31:0] instr_pc;

   modport master (
      output imem_address, imem_read, instr_valid, instr_word, instr_pc,
      input  imem_waitrequest, imem_readdata, redirect, redirect_addr, instr_ready
   );

   modport slave (
      input  imem_address, imem_read, instr_valid, instr_word, instr_pc,
      output imem_waitrequest, imem_readdata, redirect, redirect_addr, instr_ready
   );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, word} entries; head is read straight from registered storage.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read at a time, results queued in a small
// prefetch FIFO, redirects flush the queue and discard any in-flight read.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master bus
);

   localparam int unsigned   CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t  state, state_next;
   logic [31:0]   fetch_pc, fetch_pc_next;
   logic [31:0]   address, address_next;
   logic          read, read_next;
   logic [CW-1:0] count, count_after;
   logic          stalled, complete, push, pop, issue;
   fetch_entry_t  head;

   assign stalled  = read & bus.imem_waitrequest;
   assign complete = read & ~bus.imem_waitrequest;
   assign push     = complete & (state == FETCH) & ~bus.redirect;
   assign pop      = (count != '0) & bus.instr_ready;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ('{pc: address, word: bus.imem_readdata}),
      .pop       (pop),
      .flush     (bus.redirect),
      .head_data (head),
      .count     (count)
   );

   // Space is checked against the post-push/pop occupancy, so an issued read always has a slot.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      count_after   = count + CW'(push) - CW'(pop);
      if (bus.redirect) begin
         fetch_pc_next = align_word(bus.redirect_addr);
         count_after   = '0;
      end else if (push) begin
         fetch_pc_next = fetch_pc + 32'd4;
      end
      case (state)
         FETCH:   if (bus.redirect && stalled) state_next = DISCARD;
         DISCARD: if (complete)                state_next = FETCH;
      endcase
      issue        = !stalled && (count_after < DEPTH_C);
      read_next    = stalled || issue;
      address_next = issue ? fetch_pc_next : address;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_VECTOR;
         address  <= RESET_VECTOR;
         read     <= 1'b0;
      end else begin
         fetch_pc <= fetch_pc_next;
         address  <= address_next;
         read     <= read_next;
      end
   end

   assign bus.imem_address = address;
   assign bus.imem_read    = read;
   assign bus.instr_valid  = (count != '0);
   assign bus.instr_word   = head.word;
   assign bus.instr_pc     = head.pc;

   a_hold_while_stalled: assert property (
      @(posedge clk) disable iff (reset) stalled |=> (read && address == $past(address)));
   a_address_aligned: assert property (
      @(posedge clk) disable iff (reset) address[1:0] == 2'b00);
   a_count_bounded: assert property (
      @(posedge clk) disable iff (reset) count <= DEPTH_C);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit; a stream-level model checks that
// delivered instructions run sequentially from the last reset vector or redirect target.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RV = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   logic        was_stalled;
   logic [31:0] stall_addr;
   int          completions = 0;
   int          pops = 0;
   int          mark;
   logic [31:0] stalled_at;
   logic        r_wait, r_ready, r_redir;
   logic [31:0] r_addr;

   instr_fetch_unit_if ifc ();

   instr_fetch_unit #(.DEPTH(2), .RESET_VECTOR(RV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5EED_F00D;
   endfunction

   assign ifc.imem_readdata = mem_word(ifc.imem_address);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, updates the stream model for the coming edge, then waits for the next negedge.
   task automatic applyStimulus(input logic wr, input logic rdy, input logic redir, input logic [31:0] raddr);
      ifc.imem_waitrequest = wr;
      ifc.instr_ready      = rdy;
      ifc.redirect         = redir;
      ifc.redirect_addr    = raddr;
      if (was_stalled) begin
         checkOutput("stall_read_hold", 32'(ifc.imem_read), 32'd1);
         checkOutput("stall_addr_hold", ifc.imem_address, stall_addr);
      end
      if (ifc.imem_read) checkOutput("addr_align", 32'(ifc.imem_address[1:0]), 32'd0);
      if (ifc.instr_valid && rdy) begin
         checkOutput("pop_pc", ifc.instr_pc, exp_pc);
         checkOutput("pop_word", ifc.instr_word, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (redir) exp_pc = {raddr[31:2], 2'b00};
      if (ifc.imem_read && !wr) completions++;
      was_stalled = ifc.imem_read && wr;
      stall_addr  = ifc.imem_address;
      @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset       = 1'b0;
      exp_pc      = RV;
      was_stalled = 1'b0;
   endtask

   initial begin
      reset                = 1'b1;
      ifc.imem_waitrequest = 1'b0;
      ifc.instr_ready      = 1'b0;
      ifc.redirect         = 1'b0;
      ifc.redirect_addr    = '0;
      exp_pc               = RV;
      was_stalled          = 1'b0;
      stall_addr           = '0;

      @(negedge clk);
      checkOutput("reset_read", 32'(ifc.imem_read), 32'd0);
      checkOutput("reset_addr", ifc.imem_address, RV);
      checkOutput("reset_valid", 32'(ifc.instr_valid), 32'd0);
      checkOutput("reset_word", ifc.instr_word, 32'd0);
      checkOutput("reset_pc", ifc.instr_pc, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Zero-wait streaming from the reset vector
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_read", 32'(ifc.imem_read), 32'd1);
      checkOutput("t1_addr0", ifc.imem_address, RV);
      checkOutput("t1_valid0", 32'(ifc.instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_addr1", ifc.imem_address, RV + 32'd4);
      checkOutput("t1_valid1", 32'(ifc.instr_valid), 32'd1);
      checkOutput("t1_pc1", ifc.instr_pc, RV);
      checkOutput("t1_word1", ifc.instr_word, mem_word(RV));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_addr2", ifc.imem_address, RV + 32'd8);
      checkOutput("t1_pc2", ifc.instr_pc, RV + 32'd4);

      // Consumer stalls: the FIFO fills to DEPTH and reads stop
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1000);
      mark = completions;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("t2_reads_when_full", 32'(completions - mark), 32'd2);
      checkOutput("t2_read_idle", 32'(ifc.imem_read), 32'd0);
      checkOutput("t2_valid_held", 32'(ifc.instr_valid), 32'd1);
      checkOutput("t2_head_pc", ifc.instr_pc, 32'h0000_1000);
      mark = pops;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t2_drain_rate", 32'(pops - mark), 32'd4);

      // Waitrequest held for three cycles on the second fetch
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      stalled_at = ifc.imem_address;
      checkOutput("t3_stall_addr", stalled_at, RV + 32'd4);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t3_valid_s1", 32'(ifc.instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t3_valid_s3", 32'(ifc.instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t3_valid_done", 32'(ifc.instr_valid), 32'd1);
      checkOutput("t3_pc_done", ifc.instr_pc, stalled_at);
      checkOutput("t3_next_addr", ifc.imem_address, RV + 32'd8);

      // Redirect while BFC00008 is stalled: old read completes and is dropped
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      for (int i = 0; i < 2; i++) begin
         checkOutput("t4_addr_held", ifc.imem_address, RV + 32'd8);
         checkOutput("t4_valid_flushed", 32'(ifc.instr_valid), 32'd0);
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t4_target_addr", ifc.imem_address, 32'h0000_0100);
      checkOutput("t4_target_read", 32'(ifc.imem_read), 32'd1);
      checkOutput("t4_dropped", 32'(ifc.instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t4_target_valid", 32'(ifc.instr_valid), 32'd1);
      checkOutput("t4_target_pc", ifc.instr_pc, 32'h0000_0100);

      // Redirect coinciding with a zero-wait completion
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_2000);
      checkOutput("t5_empty", 32'(ifc.instr_valid), 32'd0);
      checkOutput("t5_addr", ifc.imem_address, 32'h0000_2000);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t5_pc", ifc.instr_pc, 32'h0000_2000);
      checkOutput("t5_word", ifc.instr_word, mem_word(32'h0000_2000));

      // Async reset in the middle of a stalled read
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("t6_pre_valid", 32'(ifc.instr_valid), 32'd1);
      checkOutput("t6_pre_read", 32'(ifc.imem_read), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("t6_read_drop", 32'(ifc.imem_read), 32'd0);
      checkOutput("t6_valid_drop", 32'(ifc.instr_valid), 32'd0);
      checkOutput("t6_addr_rv", ifc.imem_address, RV);
      @(negedge clk);
      @(negedge clk);
      reset       = 1'b0;
      exp_pc      = RV;
      was_stalled = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t6_restart_addr", ifc.imem_address, RV);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t6_restart_pc", ifc.instr_pc, RV);

      // Random traffic against the stream model
      mark = pops;
      for (int i = 0; i < 400; i++) begin
         r_wait  = ($urandom_range(0, 3) == 0);
         r_ready = ($urandom_range(0, 9) < 7);
         r_redir = ($urandom_range(0, 19) == 0);
         r_addr  = $urandom();
         applyStimulus(r_wait, r_ready, r_redir, r_addr);
      end
      checkOutput("random_progress", 32'(pops > mark + 50), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
